// File: rtl/arrhythmia_pkg.sv
// Shared encodings, FSM states and default thresholds for the RR-interval classifier.
package arrhythmia_pkg;

  typedef enum logic [1:0] {
    TYPE_TACHY    = 2'b00,
    TYPE_NORMAL   = 2'b01,
    TYPE_BRADY    = 2'b10,
    TYPE_ARTIFACT = 2'b11
  } type_e;

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_TRACK,
    ST_ASYS
  } state_e;

  localparam int DEF_RR_W      = 12;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_TACHY_MS  = 600;
  localparam int DEF_BRADY_MS  = 1000;
  localparam int DEF_MIN_RR_MS = 200;
  localparam int DEF_IRREG_MS  = 160;
  localparam int DEF_RUN_LEN   = 4;
  localparam int DEF_ASYS_MS   = 3000;

endpackage

// File: rtl/arrhythmia_classifier_n_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: registers are written with <= so every flop samples pre-edge values, avoiding sim/synth races.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/arrhythmia_classifier_n.sv
// Beat classifier: thresholds RR intervals, tracks irregularity, abnormal runs and asystole.
module arrhythmia_classifier_n
  import arrhythmia_pkg::*;
#(
  parameter int RR_W      = DEF_RR_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TACHY_MS  = DEF_TACHY_MS,
  parameter int BRADY_MS  = DEF_BRADY_MS,
  parameter int MIN_RR_MS = DEF_MIN_RR_MS,
  parameter int IRREG_MS  = DEF_IRREG_MS,
  parameter int RUN_LEN   = DEF_RUN_LEN,
  parameter int ASYS_MS   = DEF_ASYS_MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic [RR_W-1:0]  rr_interval_ms,
  input  logic             new_rr_pulse,
  input  logic             alarm_clr,
  output logic             result_valid,
  output logic [1:0]       type_code,
  output logic             tachy_flag,
  output logic             normal_flag,
  output logic             brady_flag,
  output logic             irregular_flag,
  output logic             run_alarm,
  output logic             asystole_flag,
  output logic [CNT_W-1:0] total_beats,
  output logic [CNT_W-1:0] tachy_count,
  output logic [CNT_W-1:0] normal_count,
  output logic [CNT_W-1:0] brady_count,
  output logic [CNT_W-1:0] artifact_count,
  output logic [CNT_W-1:0] irregular_count
);

  localparam int SIL_W = RR_W + 1;
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  localparam logic [RR_W-1:0]  MIN_T   = RR_W'(MIN_RR_MS);
  localparam logic [RR_W-1:0]  TACHY_T = RR_W'(TACHY_MS);
  localparam logic [RR_W-1:0]  BRADY_T = RR_W'(BRADY_MS);
  localparam logic [RR_W-1:0]  IRREG_T = RR_W'(IRREG_MS);
  localparam logic [SIL_W-1:0] ASYS_T  = SIL_W'(ASYS_MS);
  localparam logic [RUN_W-1:0] RUN_T   = RUN_W'(RUN_LEN);

  state_e           state;
  logic [RR_W-1:0]  prev_rr;
  logic [RUN_W-1:0] run_cnt;
  logic [SIL_W-1:0] sil_cnt;

  logic             is_art, is_tachy, is_brady, is_normal;
  logic             beat, art_evt, irreg, abnormal, run_hit, asys_hit;
  logic [RR_W-1:0]  rr_diff;
  logic [RUN_W-1:0] run_nxt;
  logic [SIL_W-1:0] sil_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_art    = rr_interval_ms < MIN_T;
    is_tachy  = !is_art && (rr_interval_ms < TACHY_T);
    is_brady  = !is_art && (rr_interval_ms > BRADY_T);
    is_normal = !is_art && !is_tachy && !is_brady;
    beat      = new_rr_pulse && !is_art;
    art_evt   = new_rr_pulse && is_art;
    rr_diff   = (rr_interval_ms >= prev_rr) ? rr_interval_ms - prev_rr : prev_rr - rr_interval_ms;
    irreg     = beat && (state == ST_TRACK) && (rr_diff > IRREG_T);
    abnormal  = beat && (is_tachy || is_brady);
    run_nxt   = (run_cnt == RUN_T) ? run_cnt : run_cnt + 1'b1;
    run_hit   = abnormal && (run_nxt == RUN_T);
    sil_nxt   = sil_cnt;
    if (beat)
      sil_nxt = '0;
    else if (ms_tick && sil_cnt != ASYS_T)
      sil_nxt = sil_cnt + 1'b1;
    asys_hit  = (state == ST_TRACK) && !beat && (sil_nxt == ASYS_T);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_FIRST;
      result_valid   <= 1'b0;
      type_code      <= TYPE_NORMAL;
      tachy_flag     <= 1'b0;
      normal_flag    <= 1'b1;
      brady_flag     <= 1'b0;
      irregular_flag <= 1'b0;
      run_alarm      <= 1'b0;
      asystole_flag  <= 1'b0;
      prev_rr        <= '0;
      run_cnt        <= '0;
      sil_cnt        <= '0;
    end else begin
      result_valid <= new_rr_pulse;
      sil_cnt      <= sil_nxt;

      if (art_evt)
        type_code <= TYPE_ARTIFACT;

      if (beat) begin
        type_code      <= is_tachy ? TYPE_TACHY : is_brady ? TYPE_BRADY : TYPE_NORMAL;
        tachy_flag     <= is_tachy;
        normal_flag    <= is_normal;
        brady_flag     <= is_brady;
        irregular_flag <= irreg;
        prev_rr        <= rr_interval_ms;
        run_cnt        <= abnormal ? run_nxt : '0;
        case (state)
          ST_FIRST: state <= ST_TRACK;
          ST_ASYS:  state <= ST_FIRST;  // history before the pause is not trusted
          default:  state <= ST_TRACK;
        endcase
      end else if (asys_hit) begin
        state <= ST_ASYS;
      end

      // Setting events take priority over a coincident clear.
      if (run_hit)
        run_alarm <= 1'b1;
      else if (alarm_clr)
        run_alarm <= 1'b0;

      if (asys_hit)
        asystole_flag <= 1'b1;
      else if (alarm_clr)
        asystole_flag <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_total (.clk(clk), .rst(rst), .inc(beat),             .count(total_beats));
  sat_counter #(.W(CNT_W)) u_tachy (.clk(clk), .rst(rst), .inc(beat && is_tachy), .count(tachy_count));
  sat_counter #(.W(CNT_W)) u_norm  (.clk(clk), .rst(rst), .inc(beat && is_normal),.count(normal_count));
  sat_counter #(.W(CNT_W)) u_brady (.clk(clk), .rst(rst), .inc(beat && is_brady), .count(brady_count));
  sat_counter #(.W(CNT_W)) u_art   (.clk(clk), .rst(rst), .inc(art_evt),          .count(artifact_count));
  sat_counter #(.W(CNT_W)) u_irreg (.clk(clk), .rst(rst), .inc(irreg),            .count(irregular_count));

endmodule

// File: doc/arrhythmia_classifier_n.md
# arrhythmia_classifier_n

Parametrised next-generation RR-interval classifier. Consumes RR intervals and their update strobe from interval detection, classifies each beat as tachy/normal/brady/artifact against parameter thresholds, and flags beat-to-beat irregularity. It keeps saturating per-class beat counters, raises a latched alarm after a run of consecutive abnormal beats, and detects asystole (no beat within a timeout). Sits between interval detection and the display/alarm logic, in the 1 kHz-tick clock domain.

## Interface
- RR_W, 12, width of RR interval in ms
- CNT_W, 16, width of each beat counter
- TACHY_MS, 600, RR < TACHY_MS is tachycardia
- BRADY_MS, 1000, RR > BRADY_MS is bradycardia
- MIN_RR_MS, 200, RR < MIN_RR_MS is artifact (not a beat class)
- IRREG_MS, 160, |RR - previous valid RR| > IRREG_MS flags irregular
- RUN_LEN, 4, consecutive abnormal beats needed to raise run_alarm (>=1)
- ASYS_MS, 3000, ms without a beat before asystole; must fit in RR_W+1 bits

- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ms_tick  in  1  1-cycle strobe, one per millisecond
- rr_interval_ms  in  RR_W  RR interval, valid when new_rr_pulse=1
- new_rr_pulse  in  1  1-cycle strobe, new interval
- alarm_clr  in  1  clears run_alarm and asystole_flag
- result_valid  out  1  1-cycle strobe, outputs updated for a beat
- type_code  out  2  00 tachy, 01 normal, 10 brady, 11 artifact
- tachy_flag / normal_flag / brady_flag  out  1 each  one-hot of last valid class
- irregular_flag  out  1  last valid beat irregular
- run_alarm  out  1  latched abnormal-run alarm
- asystole_flag  out  1  latched no-beat alarm
- total_beats, tachy_count, normal_count, brady_count, artifact_count, irregular_count  out  CNT_W each

## Operation
- Reset: type_code=01, normal_flag=1, other flags 0, all counters 0, result_valid=0, run_alarm=0, asystole_flag=0, run counter 0, silence counter 0, FSM to FIRST.
- FSM states: FIRST (no valid previous RR), TRACK, ASYS.
  - FIRST->TRACK on first non-artifact beat; irregularity not evaluated in FIRST.
  - TRACK->ASYS when silence counter reaches ASYS_MS; asystole_flag set.
  - ASYS->FIRST on next non-artifact beat (previous RR discarded); asystole_flag stays latched until alarm_clr.
- Per new_rr_pulse: classify artifact first (RR < MIN_RR_MS), then tachy (< TACHY_MS), normal (<= BRADY_MS), else brady.
- Artifact: type_code=11, artifact_count++, class flags, irregular_flag, previous RR, run counter, total_beats all unchanged; silence counter not reset.
- Valid beat: total_beats++, class count++, one-hot flags updated, previous RR <= RR, silence counter <= 0.
- Irregularity (TRACK only): absolute difference computed in RR_W bits, unsigned; irregular_flag set/cleared per beat; irregular_count++ when set.
- Run: abnormal (tachy or brady) increments run counter (saturates at RUN_LEN); normal clears it. run_alarm sets on the beat where the counter reaches RUN_LEN.
- All counters saturate at all-ones, no wrap.
- Silence counter increments on ms_tick, saturates at ASYS_MS.

## Timing
- All outputs registered; result_valid and all updates appear on the cycle after new_rr_pulse (latency 1).
- new_rr_pulse and ms_tick same cycle: beat wins, silence counter 0.
- alarm_clr with alarm-setting event same cycle: set wins.
- Pulses on consecutive cycles each processed; no back-pressure.
- rst mid-operation: full return to reset state next edge, counts lost.

## Structure
- Shared package arrhythmia_pkg: type_code encodings (TYPE_TACHY/NORMAL/BRADY/ARTIFACT), FSM state enum, default threshold constants.
- One natural sub-module: sat_counter (parametrised width, increment enable, saturate at all-ones, sync reset), instanced for the six counters.
- Irregularity, run and silence logic stay inline.

## Test plan
- Reset then RR=800 pulse -> next cycle result_valid=1, type_code=01, normal_count=1, total_beats=1, irregular_flag=0 (FIRST).
- RR sequence 800, 500, 1200 -> type_codes 01,00,10; irregular_flag 0,1,1; tachy_count=1, brady_count=1.
- RR=150 after 800 -> type_code=11, artifact_count=1, total_beats unchanged, next RR=820 gives irregular_flag=0 (compared to 800).
- Four RR=500 beats (RUN_LEN=4) -> run_alarm on 4th beat; RR=800 does not clear it; alarm_clr clears; alarm_clr coincident with 4th abnormal beat -> stays 1.
- 3000 ms_ticks with no beat -> asystole_flag=1 at tick 3000, not at 2999; beat coincident with tick 2999 prevents it.
- CNT_W=4, 17 normal beats -> normal_count and total_beats hold 15.
